// File: rtl/ila_trace_pkg.sv
// Shared layout of a hart commit trace record and the widths used by the trace arbiter.
package ila_trace_pkg;

  localparam int WDATA_LSB = 0;
  localparam int WDATA_W   = 64;
  localparam int WADDR_LSB = WDATA_LSB + WDATA_W;
  localparam int WADDR_W   = 5;
  localparam int WEN_BIT   = WADDR_LSB + WADDR_W;
  localparam int INSTR_LSB = WEN_BIT + 1;
  localparam int INSTR_W   = 32;
  localparam int PC_LSB    = INSTR_LSB + INSTR_W;
  localparam int PC_W      = 40;
  localparam int REC_W     = PC_LSB + PC_W;

  localparam int TIME_W  = 32;
  localparam int DROP_W  = 16;
  localparam int ENTRY_W = REC_W + TIME_W;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               rd_wen;
    logic [WADDR_W-1:0] rd_waddr;
    logic [WDATA_W-1:0] rd_wdata;
  } rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Per-hart trace queue: power-of-two depth, wrap-bit pointers, head entry
// presented straight from the array addressed by the registered read pointer.
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 174
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

endmodule

// File: rtl/ila_trace_arbiter.sv
// Merges per-hart commit trace streams into one timestamped beat stream with
// round-robin selection, per-hart queues and saturating drop accounting.
module ila_trace_arbiter
  import ila_trace_pkg::*;
#(
  parameter int NHARTS = 2,
  parameter int DEPTH  = 4,
  parameter int HID_W  = 3
) (
  input  logic                     uncoreclk,
  input  logic                     uncorerst_n,
  input  logic [NHARTS-1:0]        in_valid,
  input  logic [NHARTS*REC_W-1:0]  in_rec,
  input  logic [NHARTS-1:0]        hart_en,
  input  logic                     drop_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [HID_W-1:0]         out_hartid,
  output logic [TIME_W-1:0]        out_time,
  output logic [REC_W-1:0]         out_rec,
  output logic [NHARTS*DROP_W-1:0] drop_cnt,
  output logic [NHARTS-1:0]        overflow
);

  logic [TIME_W-1:0]  time_q;
  logic               out_valid_q;
  logic [HID_W-1:0]   out_hartid_q;
  logic [TIME_W-1:0]  out_time_q;
  logic [REC_W-1:0]   out_rec_q;
  logic [HID_W-1:0]   last_q;
  logic [HID_W-1:0]   grant_d;
  logic               found;
  logic               load;
  logic [ENTRY_W-1:0] sel_entry;
  logic [NHARTS-1:0]  fifo_full;
  logic [NHARTS-1:0]  fifo_empty;
  logic [NHARTS-1:0]  push;
  logic [NHARTS-1:0]  pop;
  logic [NHARTS-1:0]  drop;
  logic [ENTRY_W-1:0] fifo_rdata [NHARTS];

  // Search starts one past the last grant so every non-empty hart gets a turn.
  always_comb begin
    grant_d = last_q;
    found   = 1'b0;
    for (int k = 1; k <= NHARTS; k++) begin
      for (int i = 0; i < NHARTS; i++) begin
        if (!found && !fifo_empty[i] && i == (int'(last_q) + k) % NHARTS) begin
          found   = 1'b1;
          grant_d = HID_W'(i);
        end
      end
    end
    load      = found && (!out_valid_q || out_ready);
    pop       = '0;
    sel_entry = '0;
    for (int i = 0; i < NHARTS; i++) begin
      if (load && grant_d == HID_W'(i)) begin
        pop[i]    = 1'b1;
        sel_entry = fifo_rdata[i];
      end
    end
  end

  always_ff @(posedge uncoreclk or negedge uncorerst_n) begin
    if (!uncorerst_n) begin
      time_q       <= '0;
      out_valid_q  <= 1'b0;
      out_hartid_q <= '0;
      out_time_q   <= '0;
      out_rec_q    <= '0;
      last_q       <= HID_W'(NHARTS - 1);
    end else begin
      time_q <= time_q + TIME_W'(1);
      if (load) begin
        out_valid_q  <= 1'b1;
        out_hartid_q <= grant_d;
        out_rec_q    <= sel_entry[ENTRY_W-1 -: REC_W];
        out_time_q   <= sel_entry[TIME_W-1:0];
        last_q       <= grant_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_hartid = out_hartid_q;
  assign out_time   = out_time_q;
  assign out_rec    = out_rec_q;

  for (genvar gi = 0; gi < NHARTS; gi++) begin : g_hart
    logic [DROP_W-1:0] drop_cnt_q;
    logic              overflow_q;

    // A full queue still accepts when its head leaves in the same cycle.
    assign push[gi] = in_valid[gi] & hart_en[gi] & (~fifo_full[gi] | pop[gi]);
    assign drop[gi] = in_valid[gi] & hart_en[gi] & fifo_full[gi] & ~pop[gi];

    trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clk   (uncoreclk),
      .rst_n (uncorerst_n),
      .push  (push[gi]),
      .wdata ({in_rec[gi*REC_W +: REC_W], time_q}),
      .pop   (pop[gi]),
      .rdata (fifo_rdata[gi]),
      .full  (fifo_full[gi]),
      .empty (fifo_empty[gi])
    );

    always_ff @(posedge uncoreclk or negedge uncorerst_n) begin
      if (!uncorerst_n) begin
        drop_cnt_q <= '0;
        overflow_q <= 1'b0;
      end else if (drop_clr) begin
        drop_cnt_q <= '0;
        overflow_q <= 1'b0;
      end else if (drop[gi]) begin
        if (drop_cnt_q != DROP_MAX) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
        overflow_q <= 1'b1;
      end
    end

    assign drop_cnt[gi*DROP_W +: DROP_W] = drop_cnt_q;
    assign overflow[gi]                  = overflow_q;
  end

endmodule

// File: tb/tb_ila_trace_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for overflow,
// async reset and counter saturation, plus randomized traffic vs a queue model.
module tb_ila_trace_arbiter;
  import ila_trace_pkg::*;

  localparam int NH = 2;
  localparam int DP = 4;
  localparam int HW = 3;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [NH-1:0]     iv    = '0;
  logic [NH-1:0]     en    = '0;
  logic              clr   = 1'b0;
  logic              rdy   = 1'b0;
  logic [REC_W-1:0]  rec_in [NH];
  logic [NH*REC_W-1:0] in_rec;
  logic              out_valid;
  logic [HW-1:0]     out_hartid;
  logic [31:0]       out_time;
  logic [REC_W-1:0]  out_rec;
  logic [NH*16-1:0]  drop_cnt;
  logic [NH-1:0]     overflow;

  assign in_rec = {rec_in[1], rec_in[0]};

  ila_trace_arbiter #(.NHARTS(NH), .DEPTH(DP), .HID_W(HW)) dut (
    .uncoreclk  (clk),
    .uncorerst_n(rst_n),
    .in_valid   (iv),
    .in_rec     (in_rec),
    .hart_en    (en),
    .drop_clr   (clr),
    .out_valid  (out_valid),
    .out_ready  (rdy),
    .out_hartid (out_hartid),
    .out_time   (out_time),
    .out_rec    (out_rec),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string nm, logic [191:0] act, logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mk_rec(int h, logic [31:0] t);
    rec_t r;
    r.pc       = {8'(h) + 8'hA0, t};
    r.instr    = t ^ 32'h1357_9BDF ^ 32'(h);
    r.rd_wen   = t[0];
    r.rd_waddr = t[4:0];
    r.rd_wdata = {~t, t + 32'(h)};
    return r;
  endfunction

  // Reference model: one queue per hart, a single output slot, a rotating grant.
  typedef struct {
    logic [REC_W-1:0] rec;
    logic [31:0]      tm;
  } ent_t;

  ent_t        mq [NH][$];
  bit          m_valid;
  int          m_hid;
  int          m_last;
  ent_t        m_ent;
  logic [31:0] m_time;
  int          m_cnt [NH];
  bit          m_ov  [NH];
  bit          model_chk = 1'b0;

  task automatic model_reset();
    for (int h = 0; h < NH; h++) begin
      mq[h].delete();
      m_cnt[h] = 0;
      m_ov[h]  = 1'b0;
    end
    m_valid = 1'b0;
    m_hid   = 0;
    m_last  = NH - 1;
    m_time  = '0;
  endtask

  task automatic model_tick();
    int g;
    g = -1;
    if (!m_valid || rdy) begin
      for (int k = 1; k <= NH; k++) begin
        int idx;
        idx = (m_last + k) % NH;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
    end
    if (g >= 0) begin
      m_ent   = mq[g].pop_front();
      m_hid   = g;
      m_last  = g;
      m_valid = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    for (int h = 0; h < NH; h++) begin
      if (iv[h] && en[h]) begin
        if (mq[h].size() < DP) begin
          ent_t e;
          e.rec = rec_in[h];
          e.tm  = m_time;
          mq[h].push_back(e);
        end else begin
          if (m_cnt[h] < 65535) m_cnt[h]++;
          m_ov[h] = 1'b1;
        end
      end
    end
    if (clr) begin
      for (int h = 0; h < NH; h++) begin
        m_cnt[h] = 0;
        m_ov[h]  = 1'b0;
      end
    end
    m_time = m_time + 32'd1;
  endtask

  task automatic compare_model();
    chk("rnd_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("rnd_hartid", out_hartid, m_hid);
      chk("rnd_time", out_time, m_ent.tm);
      chk("rnd_rec", out_rec, m_ent.rec);
    end
    for (int h = 0; h < NH; h++) begin
      chk("rnd_drop", drop_cnt[h*16 +: 16], m_cnt[h]);
      chk("rnd_ovf", overflow[h], m_ov[h]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    if (model_chk) compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    iv    = '0;
    en    = '0;
    rdy   = 1'b0;
    clr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] iv;
    logic [1:0] en;
    bit         rdy;
    bit         ev;
    int         eh;
    int         et;
  } vec_t;

  vec_t tbl [$];

  task automatic add_row(bit r, logic [1:0] v, logic [1:0] e, bit rd, bit ev, int eh, int et);
    vec_t x;
    x.rst = r; x.iv = v; x.en = e; x.rdy = rd; x.ev = ev; x.eh = eh; x.et = et;
    tbl.push_back(x);
  endtask

  int got;

  initial begin
    for (int h = 0; h < NH; h++) rec_in[h] = '0;

    // Segment A: single push at time 10; hart 1 valid while disabled is ignored.
    for (int r = 0; r < 10; r++)
      add_row(r == 0, 2'b00, 2'b11, 1'b1, 1'b0, 0, 0);
    tbl[5].iv = 2'b10;
    tbl[5].en = 2'b01;
    add_row(0, 2'b01, 2'b11, 1, 0, 0, 0);
    add_row(0, 2'b00, 2'b11, 1, 1, 0, 10);
    add_row(0, 2'b00, 2'b11, 1, 0, 0, 0);
    // Segment B: both harts push for four cycles; output alternates 0,1,0,1.
    add_row(1, 2'b11, 2'b11, 1, 0, 0, 0);
    add_row(0, 2'b11, 2'b11, 1, 1, 0, 0);
    add_row(0, 2'b11, 2'b11, 1, 1, 1, 0);
    add_row(0, 2'b11, 2'b11, 1, 1, 0, 1);
    add_row(0, 2'b00, 2'b11, 1, 1, 1, 1);
    add_row(0, 2'b00, 2'b11, 1, 1, 0, 2);
    add_row(0, 2'b00, 2'b11, 1, 1, 1, 2);
    add_row(0, 2'b00, 2'b11, 1, 1, 0, 3);
    add_row(0, 2'b00, 2'b11, 1, 1, 1, 3);
    add_row(0, 2'b00, 2'b11, 1, 0, 0, 0);

    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_hartid", out_hartid, 0);
    chk("rst_time", out_time, 0);
    chk("rst_rec", out_rec, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ovf", overflow, 0);

    foreach (tbl[r]) begin
      if (tbl[r].rst) do_reset();
      iv  = tbl[r].iv;
      en  = tbl[r].en;
      rdy = tbl[r].rdy;
      for (int h = 0; h < NH; h++) rec_in[h] = mk_rec(h, m_time);
      step();
      chk("tbl_valid", out_valid, tbl[r].ev);
      if (tbl[r].ev) begin
        chk("tbl_hartid", out_hartid, tbl[r].eh);
        chk("tbl_time", out_time, tbl[r].et);
        chk("tbl_rec", out_rec, mk_rec(tbl[r].eh, tbl[r].et));
      end
      chk("tbl_drop", drop_cnt, 0);
      chk("tbl_ovf", overflow, 0);
      $display("row %0d: iv=%b en=%b rdy=%b -> valid=%b hart=%0d time=%0d",
               r, tbl[r].iv, tbl[r].en, tbl[r].rdy, out_valid, out_hartid, out_time);
    end

    // Hart 1 pushes six records into a stalled sink: one drop, first five survive.
    do_reset();
    en = 2'b11;
    for (int c = 0; c < 6; c++) begin
      iv = 2'b10;
      rec_in[1] = mk_rec(1, m_time);
      step();
    end
    iv = '0;
    step();
    chk("ovr_drop1", drop_cnt[31:16], 1);
    chk("ovr_ovf1", overflow[1], 1);
    chk("ovr_drop0", drop_cnt[15:0], 0);
    chk("ovr_held", out_valid, 1);
    rdy = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (got < 5) begin
          chk("ovr_hartid", out_hartid, 1);
          chk("ovr_time", out_time, got);
          chk("ovr_rec", out_rec, mk_rec(1, got));
          $display("drain beat %0d: hart=%0d time=%0d", got, out_hartid, out_time);
        end
        got++;
      end
      step();
    end
    chk("ovr_count", got, 5);

    // Asynchronous reset while a beat is held.
    do_reset();
    en = 2'b01;
    iv = 2'b01;
    for (int c = 0; c < 3; c++) begin
      rec_in[0] = mk_rec(0, m_time);
      step();
    end
    iv = '0;
    step();
    chk("arst_before", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_time", out_time, 0);
    chk("arst_rec", out_rec, 0);
    chk("arst_hartid", out_hartid, 0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("arst_empty", out_valid, 0);
    end
    $display("async reset: output cleared, queues empty after release");

    // Randomized traffic: strict 1/0 ready toggling first, then random ready.
    do_reset();
    model_chk = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      iv = NH'($urandom);
      for (int h = 0; h < NH; h++) begin
        en[h]     = ($urandom_range(0, 9) < 8);
        rec_in[h] = mk_rec(h, $urandom);
      end
      rdy = (c < 1000) ? ((c % 2) == 0) : 1'($urandom);
      clr = ($urandom_range(0, 63) == 0);
      step();
    end
    model_chk = 1'b0;
    clr = 1'b0;
    $display("random phase: 3000 cycles compared against model");

    // Drop counter saturation and clear behaviour.
    do_reset();
    en = 2'b01;
    iv = 2'b01;
    rec_in[0] = mk_rec(0, 0);
    for (int c = 0; c < 1005; c++) step();
    chk("sat_mid", drop_cnt[15:0], 1000);
    for (int c = 0; c < 65000; c++) step();
    chk("sat_max", drop_cnt[15:0], 16'hFFFF);
    chk("sat_ovf", overflow[0], 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_coinc_cnt", drop_cnt[15:0], 0);
    chk("clr_coinc_ovf", overflow[0], 0);
    step();
    chk("after_clr_cnt", drop_cnt[15:0], 1);
    chk("after_clr_ovf", overflow[0], 1);
    iv  = '0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_cnt", drop_cnt[15:0], 0);
    chk("clr_ovf", overflow[0], 0);
    $display("saturation: counter clamped and cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
